// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, word-length codes and RBR bit positions
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;
  localparam int RBR_PE = 8;
  localparam int RBR_FE = 9;
  localparam int RBR_BI = 10;
  function automatic logic [3:0] wls_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for asynchronous inputs, resets to 1 (idle line level)
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff_q;
  always_ff @(posedge pclk)
    ff_q <= !presetn ? '1 : {ff_q[STAGES-2:0], d_i};
  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 16x-oversampled UART receive framer delivering {bi, fe, pe, data} with a done strobe
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        urrst,
  input  logic        baud_tick,
  input  logic        rxd,
  input  logic        loop,
  input  logic        txd_loop,
  input  logic [1:0]  wls,
  input  logic        pen,
  input  logic        eps,
  input  logic        sp,
  output logic [10:0] rbr,
  output logic        receive_done,
  output logic        error_check,
  output logic        parity_error,
  output logic        frame_error,
  output logic        uart_break,
  output logic        rx_busy
);
  localparam logic [3:0] HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] FULL = 4'(OVERSAMPLE - 1);
  rx_state_e   st_q, st_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        pe_q, pe_d, par_q, par_d;
  logic [1:0]  wls_q, wls_d;
  logic        pen_q, pen_d, eps_q, eps_d, sp_q, sp_d;
  logic [10:0] rbr_q, rbr_d;
  logic        done_q, done_d;
  logic        en_q, rst_n, rx_s, tick, mid, last_bit, exp_par;
  assign rst_n = presetn & urrst;
  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .pclk   (pclk),
    .presetn(rst_n),
    .d_i    (loop ? txd_loop : rxd),
    .q_o    (rx_s)
  );
  // en_q masks the tick that coincides with leaving reset
  assign tick     = baud_tick & en_q;
  assign mid      = tick && cnt_q == (st_q == START ? HALF : FULL);
  assign last_bit = idx_q == 3'(wls_bits(wls_q) - 4'd1);
  assign exp_par  = sp_q ? ~eps_q : ^sh_q ^ ~eps_q;
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    sh_d   = sh_q;
    pe_d   = pe_q;
    par_d  = par_q;
    wls_d  = wls_q;
    pen_d  = pen_q;
    eps_d  = eps_q;
    sp_d   = sp_q;
    rbr_d  = rbr_q;
    done_d = 1'b0;
    if (tick) begin
      cnt_d = (mid || st_q == IDLE || st_q == WAIT_HIGH) ? 4'd0 : cnt_q + 4'd1;
      case (st_q)
        IDLE: if (!rx_s) begin
          st_d  = START;
          sh_d  = '0;
          pe_d  = 1'b0;
          par_d = 1'b0;
          wls_d = wls;
          pen_d = pen;
          eps_d = eps;
          sp_d  = sp;
        end
        START: if (mid) begin
          st_d  = rx_s ? IDLE : DATA;
          idx_d = 3'd0;
        end
        DATA: if (mid) begin
          sh_d[idx_q] = rx_s;
          idx_d       = idx_q + 3'd1;
          if (last_bit) st_d = pen_q ? PARITY : STOP;
        end
        PARITY: if (mid) begin
          par_d = rx_s;
          pe_d  = rx_s != exp_par;
          st_d  = STOP;
        end
        // break needs every bit of the frame low, parity included when present
        STOP: if (mid) begin
          rbr_d  = {~rx_s && sh_q == 8'd0 && !par_q, ~rx_s, pe_q, sh_q};
          done_d = 1'b1;
          st_d   = rx_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: if (rx_s) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      pe_q   <= 1'b0;
      par_q  <= 1'b0;
      wls_q  <= WLS_5;
      pen_q  <= 1'b0;
      eps_q  <= 1'b0;
      sp_q   <= 1'b0;
      rbr_q  <= '0;
      done_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      pe_q   <= pe_d;
      par_q  <= par_d;
      wls_q  <= wls_d;
      pen_q  <= pen_d;
      eps_q  <= eps_d;
      sp_q   <= sp_d;
      rbr_q  <= rbr_d;
      done_q <= done_d;
      en_q   <= 1'b1;
    end
  end
  assign rbr          = rbr_q;
  assign receive_done = done_q;
  assign error_check  = done_q;
  assign parity_error = rbr_q[RBR_PE];
  assign frame_error  = rbr_q[RBR_FE];
  assign uart_break   = rbr_q[RBR_BI];
  assign rx_busy      = st_q != IDLE;
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: table-driven frame vectors plus break, glitch, reset-abort and back-to-back sequences
module tb_uart_rx_deser;
  localparam int BIT_CYC = 64;
  typedef struct {
    logic [1:0]  wls;
    logic        pen, eps, sp, lp, par, stp, chg;
    logic [7:0]  data;
    logic [10:0] exp;
  } vec_t;
  logic        pclk = 1'b0;
  logic        presetn, urrst, baud_tick, rxd, loop, txd_loop, pen, eps, sp;
  logic [1:0]  wls;
  logic [10:0] rbr;
  logic        receive_done, error_check, parity_error, frame_error, uart_break, rx_busy;
  int          checks = 0;
  int          errors = 0;
  int          nstb = 0;
  logic [10:0] cap_rbr [4];
  logic [2:0]  cap_fl [4];
  logic        cap_ec [4];
  vec_t        vecs [10];
  uart_rx_deser dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .urrst       (urrst),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .loop        (loop),
    .txd_loop    (txd_loop),
    .wls         (wls),
    .pen         (pen),
    .eps         (eps),
    .sp          (sp),
    .rbr         (rbr),
    .receive_done(receive_done),
    .error_check (error_check),
    .parity_error(parity_error),
    .frame_error (frame_error),
    .uart_break  (uart_break),
    .rx_busy     (rx_busy)
  );
  always #5 pclk = ~pclk;
  initial begin
    int t;
    t = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge pclk);
      baud_tick = (t == 3);
      t = (t + 1) % 4;
    end
  end
  always @(negedge pclk) begin
    if (receive_done) begin
      if (nstb < 4) begin
        cap_rbr[nstb] = rbr;
        cap_fl[nstb]  = {uart_break, frame_error, parity_error};
        cap_ec[nstb]  = error_check;
      end
      nstb = nstb + 1;
    end
  end
  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask
  task automatic put(input logic lp, input logic b);
    if (lp) txd_loop = b;
    else rxd = b;
    cyc(BIT_CYC);
  endtask
  task automatic cfg(input vec_t v);
    wls = v.wls; pen = v.pen; eps = v.eps; sp = v.sp; loop = v.lp;
    rxd = 1'b1; txd_loop = v.lp;
  endtask
  task automatic send(input vec_t v, input int idle_bits);
    put(v.lp, 1'b0);
    if (v.chg) begin
      wls = ~wls;
      pen = ~pen;
    end
    for (int i = 0; i < 5 + int'(v.wls); i++) put(v.lp, v.data[i]);
    if (v.pen) put(v.lp, v.par);
    put(v.lp, v.stp);
    for (int i = 0; i < idle_bits; i++) put(v.lp, 1'b1);
  endtask
  task automatic chk_frame(input string nm, input int k, input logic [10:0] exp);
    chk({nm, "_rbr"}, cap_rbr[k], exp);
    chk({nm, "_flags"}, 11'(cap_fl[k]), 11'(exp[10:8]));
    chk({nm, "_error_check"}, 11'(cap_ec[k]), 11'd1);
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 11'h0A5};
    vecs[1] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 11'h0A5};
    vecs[2] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 11'h013};
    vecs[3] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h13, 11'h113};
    vecs[4] = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 11'h155};
    vecs[5] = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 11'h055};
    vecs[6] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 11'h03C};
    vecs[7] = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEB, 11'h02B};
    vecs[8] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 11'h281};
    vecs[9] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 11'h000};
    presetn = 1'b0; urrst = 1'b1;
    cfg(vecs[0]);
    cyc(5);
    chk("reset_rbr", rbr, 11'h000);
    chk("reset_done", 11'(receive_done), 11'd0);
    chk("reset_busy", 11'(rx_busy), 11'd0);
    presetn = 1'b1;
    cyc(BIT_CYC);
    for (int i = 0; i < 10; i++) begin
      cfg(vecs[i]);
      cyc(8);
      nstb = 0;
      send(vecs[i], 2);
      chk($sformatf("v%0d_strobes", i), 11'(nstb), 11'd1);
      chk_frame($sformatf("v%0d", i), 0, vecs[i].exp);
    end
    v = vecs[0];
    cfg(v);
    nstb = 0;
    rxd = 1'b0;
    cyc(20 * BIT_CYC);
    chk("break_strobes", 11'(nstb), 11'd1);
    chk_frame("break", 0, 11'h600);
    chk("break_wait_busy", 11'(rx_busy), 11'd1);
    rxd = 1'b1;
    cyc(3 * BIT_CYC);
    chk("break_release_strobes", 11'(nstb), 11'd1);
    chk("break_release_busy", 11'(rx_busy), 11'd0);
    v.data = 8'h5A;
    send(v, 2);
    chk("after_break_strobes", 11'(nstb), 11'd2);
    chk_frame("after_break", 1, 11'h05A);
    nstb = 0;
    rxd = 1'b0;
    cyc(12);
    chk("glitch_busy", 11'(rx_busy), 11'd1);
    rxd = 1'b1;
    cyc(2 * BIT_CYC);
    chk("glitch_strobes", 11'(nstb), 11'd0);
    chk("glitch_idle", 11'(rx_busy), 11'd0);
    v.data = 8'h0F;
    fork
      send(v, 2);
      begin
        cyc(3 * BIT_CYC);
        chk("abort_busy_before", 11'(rx_busy), 11'd1);
        urrst = 1'b0;
        cyc(1);
        chk("abort_busy_after", 11'(rx_busy), 11'd0);
      end
    join
    urrst = 1'b1;
    cyc(BIT_CYC);
    chk("abort_strobes", 11'(nstb), 11'd0);
    v.data = 8'hC3;
    send(v, 2);
    chk("recover_strobes", 11'(nstb), 11'd1);
    chk_frame("recover", 0, 11'h0C3);
    nstb = 0;
    v.data = 8'h96;
    send(v, 0);
    v.data = 8'h69;
    send(v, 2);
    chk("b2b_strobes", 11'(nstb), 11'd2);
    chk_frame("b2b_first", 0, 11'h096);
    chk_frame("b2b_second", 1, 11'h069);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
